// File: rtl/watchdog_timer.sv
// Host-kicked watchdog: fires a pulse_cycles-wide int_reset when not kicked within timeout_cycles.
// Commands land on the edge after wr_strobe; outputs are decoded straight from registered state.
module watchdog_timer #(
    parameter int unsigned timeout_cycles = 1000000,
    parameter int unsigned warn_cycles    = 65536,
    parameter int unsigned pulse_cycles   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    output logic       int_reset,
    output logic       armed,
    output logic       warning,
    output logic       unlock_pending
);

    localparam int CW = $clog2(timeout_cycles + 1);
    localparam int PW = $clog2(pulse_cycles + 1);

    localparam logic [CW-1:0] RELOAD     = CW'(timeout_cycles - 1);
    localparam logic [CW-1:0] WARN_TH    = CW'(warn_cycles);
    localparam logic [PW-1:0] PULSE_LAST = PW'(pulse_cycles - 1);

    localparam logic [7:0] CMD_KICK   = 8'hA5;
    localparam logic [7:0] CMD_SWRST  = 8'hE1;
    localparam logic [7:0] CMD_UNLOCK = 8'h5A;
    localparam logic [7:0] CMD_DISARM = 8'h3C;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [PW-1:0]   pcnt, pcnt_nxt;
    logic [7:0]      ucnt, ucnt_nxt;
    logic            pend, pend_nxt;

    logic            is_kick, is_swrst, is_disarm, enter_fire;

    assign is_kick   = wr_strobe && (wr_data == CMD_KICK);
    assign is_swrst  = wr_strobe && (wr_data == CMD_SWRST);
    assign is_disarm = wr_strobe && (wr_data == CMD_DISARM) && pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DISARMED;
            count <= '0;
            pcnt  <= '0;
            ucnt  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            pcnt  <= pcnt_nxt;
            ucnt  <= ucnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        pcnt_nxt   = pcnt;
        ucnt_nxt   = ucnt;
        pend_nxt   = pend;
        enter_fire = 1'b0;

        // Any write resolves the unlock window; 0xFF means this is the 256th idle cycle.
        if (wr_strobe) begin
            pend_nxt = (wr_data == CMD_UNLOCK);
            ucnt_nxt = 8'd0;
        end else if (pend) begin
            ucnt_nxt = ucnt + 8'd1;
            if (ucnt == 8'hFF) begin
                pend_nxt = 1'b0;
            end
        end

        case (state)
            DISARMED: begin
                if (is_swrst) begin
                    enter_fire = 1'b1;
                end else if (is_kick) begin
                    state_nxt = ARMED;
                    count_nxt = RELOAD;
                end
            end
            ARMED: begin
                // Host commands outrank expiry in the same cycle.
                if (is_swrst) begin
                    enter_fire = 1'b1;
                end else if (is_kick) begin
                    count_nxt = RELOAD;
                end else if (is_disarm) begin
                    state_nxt = DISARMED;
                end else if (count == '0) begin
                    enter_fire = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            FIRE: begin
                if (pcnt == PULSE_LAST) begin
                    state_nxt = DISARMED;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = DISARMED;
            end
        endcase

        if (enter_fire) begin
            state_nxt = FIRE;
            pcnt_nxt  = '0;
            pend_nxt  = 1'b0;
        end
    end

    assign int_reset      = (state == FIRE);
    assign armed          = (state == ARMED);
    assign warning        = (state == ARMED) && (count < WARN_TH);
    assign unlock_pending = pend;

endmodule

// File: doc/watchdog_timer.md
# watchdog_timer

Host-programmable watchdog that sits directly upstream of the reset generator and drives its `int_reset` input. Once armed, the host must write a kick key before a programmable timeout expires; otherwise the block emits a fixed-width `int_reset` pulse that restarts the core. It also provides an immediate software-reset command and a two-write unlock sequence for disarming. It is clocked by the core clock and reset by the reset generator's `reset` output.

## Interface
- `timeout_cycles`, 1000000: clock cycles from arm/kick to fire. Must be ≥ 2.
- `warn_cycles`, 65536: `warning` is asserted while fewer than this many cycles remain. Must be < `timeout_cycles`.
- `pulse_cycles`, 4: width of the `int_reset` pulse. Must be ≥ 1.
- `clk` in 1: core clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset. Puts the block in DISARMED with all outputs 0.
- `wr_strobe` in 1: single-cycle command write qualifier.
- `wr_data` in 8: command byte, sampled when `wr_strobe`=1.
- `int_reset` out 1: registered reset-request pulse to the reset generator. Reset value 0.
- `armed` out 1: 1 in ARMED. Reset value 0.
- `warning` out 1: `armed` && count < `warn_cycles`. Reset value 0.
- `unlock_pending` out 1: a disarm unlock byte was received and is awaiting confirmation. Reset value 0.

## Operation
- States:
  - DISARMED: count idle.
  - ARMED: count decrements by 1 per cycle.
  - FIRE: `int_reset`=1; pulse counter runs.
- Down-counter width is floor(log2(`timeout_cycles`))+1 bits. The pulse counter and the unlock counter are sized the same way from their own limits.
- Commands are taken only when `wr_strobe`=1:
  - 0xA5, kick/arm: in DISARMED → ARMED, count loaded with `timeout_cycles`−1. In ARMED, count is reloaded with `timeout_cycles`−1. In FIRE, ignored.
  - 0xE1, software reset: in DISARMED or ARMED → FIRE immediately. In FIRE, ignored.
  - 0x5A, unlock: sets `unlock_pending` and clears the 8-bit unlock window counter.
  - 0x3C with `unlock_pending`=1, disarm: ARMED → DISARMED. Clears `unlock_pending`. Count is not reloaded.
  - 0x3C with `unlock_pending`=0: ignored.
  - Any other byte: ignored.
- Any write other than 0x5A clears `unlock_pending` and is then processed normally. Example: 0x5A followed by 0xA5 clears pending, then kicks.
- While `unlock_pending`=1 with no write, the window counter increments. On the 256th cycle without a write, pending clears.
- ARMED with count==0 and no 0xA5/0xE1/disarm in that cycle → FIRE. Kick, software reset and disarm all take priority over expiry in the same cycle.
- In FIRE, the pulse counter runs for `pulse_cycles` cycles, then the block goes to DISARMED with `int_reset` back to 0. The block never re-arms automatically.
- Entering FIRE clears `unlock_pending`.
- Because the reset generator reasserts `reset`, the pulse is normally truncated by the block's own asynchronous reset. This is intended: the reset generator latches the request on the first high cycle. Full `pulse_cycles` width is required only when `reset` stays low.

## Timing
- Commands take effect at the clock edge following the `wr_strobe` cycle. `armed`, `unlock_pending` and `int_reset` update on that edge.
- With no further kicks, `int_reset` rises exactly `timeout_cycles` edges after the edge that registered the arm/kick.
- After 0xE1, `int_reset` rises on the next edge.
- `int_reset` stays high for exactly `pulse_cycles` cycles when `reset` stays low. `armed`=0 throughout FIRE.
- `warning` is combinational from registered state and count, so it has no extra latency.
- An asynchronous `reset` at any point, including mid-pulse or mid-unlock, forces DISARMED and all outputs 0 immediately. Operation resumes on the first edge after `reset` deasserts.

## Test plan
- Arm then idle (T=16, W=4, P=4): write 0xA5 at cycle 0. Required: `armed`=1 from cycle 1; `warning`=1 from cycle 13; `int_reset`=1 for cycles 17–20; `armed`=0 from cycle 17; DISARMED at cycle 21.
- Kick at the boundary: re-kick with 0xA5 in the same cycle count==0. Required: no fire; `int_reset` rises 16 edges after the kick edge.
- Software reset: 0xE1 while DISARMED. Required: `int_reset`=1 on the next edge for 4 cycles. A 0xA5 written during FIRE is ignored.
- Unlock/disarm: 0x5A then 0x3C while armed. Required: `armed` drops on the edge after 0x3C; no fire later. Repeat the sequence with 255 idle cycles between the writes: disarms. Repeat with 256 idle cycles: pending cleared and still armed.
- Broken unlock: 0x5A, 0x00, 0x3C. Required: `unlock_pending` clears on 0x00, the block stays armed, and it fires on schedule.
- Async reset mid-pulse: assert `reset` during cycle 2 of FIRE. Required: `int_reset`=0 immediately; DISARMED; `armed`=0 after release.
